write_back: RTL and testbench
=============================

Name: write_back

Overview:
- Final pipeline stage; receiving end of the execute-to-write handshake.
- Accepts one result per cycle from execute and commits it in one of three ways:
  - register writes through the register-file write port;
  - flag updates through a dedicated flags write port;
  - stores through an Avalon-MM style memory master with optional address-register post-adjust.
- Back-pressures execute via hold while a store is outstanding.

Parameters:
- REG_INDEX_BITS, 5, width of register index (32 registers; index 0 reads zero, never written).
- FLAGS_REG, 31, index of flags register written by the flags port.

Ports:
- clock  in  1  system clock
- reset_n  in  1  async active-low reset
- in_valid  in  1  execute result valid
- in_pc  in  32  pc of the instruction
- in_destination_register  in  REG_INDEX_BITS  target register, or address register for stores; 0 = no commit
- in_is_writing_memory  in  1  instruction is a store
- in_flags  in  4  {carry, negative, overflow, zero}
- in_destination_value  in  32  result value, or store data
- in_adjustment_value  in  32  store post-adjust amount (0 = none)
- in_has_flushed  in  1  flush marker from execute
- hold  out  1  back-pressure to execute
- rf_read_index  out  REG_INDEX_BITS  address-register read index
- rf_read_value  in  32  register-file read data, combinational
- rf_write_enable  out  1  register write strobe
- rf_write_index  out  REG_INDEX_BITS  register write index
- rf_write_value  out  32  register write data
- flags_write_enable  out  1  flags write strobe
- flags_write_value  out  32  new flags register value
- mem_address  out  32  store address
- mem_writedata  out  32  store data
- mem_write  out  1  store request
- mem_waitrequest  in  1  memory stall
- retired_pc  out  32  pc of last committed instruction
- has_flushed  out  1  registered copy of in_has_flushed

Behaviour:
- Reset and clock: reset reset_n, asynchronous, active-low; clock clock.
- Outputs at reset: all strobes 0, mem_write 0, all data/address outputs 0, retired_pc 0, has_flushed 0, FSM IDLE.
- hold = reset_n && (state != IDLE).
- rf_read_index = in_destination_register, combinational.
- Accept condition: in_valid && state == IDLE. has_flushed <= in_has_flushed every cycle hold is low, whether or not in_valid.

Non-store accept:
- Next cycle: rf_write_enable = 1 for exactly one cycle, with rf_write_index/rf_write_value = in_destination_register/in_destination_value. Suppressed when index is 0.
- Same cycle: flags_write_enable = 1, flags_write_value = in_flags placed at bits [30:27] (carry at 30), all other bits 0.
- retired_pc <= in_pc.

Store accept (in_is_writing_memory = 1, in_destination_register != 0):
- Capture base = rf_read_value, with bypass: if rf_write_enable && rf_write_index == rf_read_index this cycle, base = rf_write_value.
- Capture data = in_destination_value and adj = in_adjustment_value. Flags are not written.
- Enter STORE.

FSM states:
- IDLE: accepts as above.
- STORE: mem_write = 1, mem_address = base, mem_writedata = data, all held stable while mem_waitrequest = 1.
  - On cycle with mem_waitrequest = 0: mem_write drops the next cycle and retired_pc <= pc.
  - Then go to UPDATE if adj != 0, else IDLE.
- UPDATE: one-cycle rf_write_enable, with index = address register and value = base + adj (mod 2^32). Then IDLE.

Edge cases:
- Store with in_destination_register = 0 (failed conditional store): no memory access, no flags write; retired_pc updates; stays IDLE.
- in_valid while hold = 1: ignored. Execute keeps presenting the instruction until hold falls.
- Reset mid-STORE: mem_write drops immediately, FSM returns to IDLE, and the pending post-adjust is discarded.
- Minimum store occupancy: 1 cycle (mem_waitrequest = 0 at first request). Add 1 cycle when adj != 0.

Optional Feature:
- Macro: WRITE_BACK_RETIRE_COUNT_EN.
- When defined: extra port retired_count out 32. Reset 0; increments by 1 per committed instruction (non-store accept, completed store, or squashed store). Wraps 0xFFFFFFFF -> 0. Flushed/invalid cycles do not count.
- When undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Register op: in_valid=1, dest=5, value=0x12345678, flags=4'b1001 -> next cycle rf_write_enable=1 idx 5 value 0x12345678; flags_write_value=0x48000000; hold stays 0.
- Dest 0 op: in_valid=1, dest=0, value=0xFFFFFFFF -> rf_write_enable stays 0; flags still written.
- Store with stall: dest=3, rf_read_value=0x1000, data=0xCAFE, adj=0, mem_waitrequest high 3 cycles -> mem_write high 4 cycles at addr 0x1000; hold high for that duration; no rf write.
- Post-adjust store: base 0x2000, adj=4, no stall -> one mem write to 0x2000, then rf write idx 3 value 0x2004; hold high 2 cycles.
- Bypass: register op writing r3=0x3000, immediately followed by store via r3 -> mem_address=0x3000.
- Reset mid-STORE with mem_waitrequest=1 -> mem_write=0 and hold=0 immediately; no UPDATE write after reset release.

Source files
------------

// File: rtl/write_back.sv
// write_back: final pipeline stage committing register, flags and store results.
// Optional retired-instruction counter enabled by defining WRITE_BACK_RETIRE_COUNT_EN.
module write_back #(
  parameter int REG_INDEX_BITS = 5,
  parameter int FLAGS_REG = 31
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      in_valid,
  input  logic [31:0]               in_pc,
  input  logic [REG_INDEX_BITS-1:0] in_destination_register,
  input  logic                      in_is_writing_memory,
  input  logic [3:0]                in_flags,
  input  logic [31:0]               in_destination_value,
  input  logic [31:0]               in_adjustment_value,
  input  logic                      in_has_flushed,
  output logic                      hold,
  output logic [REG_INDEX_BITS-1:0] rf_read_index,
  input  logic [31:0]               rf_read_value,
  output logic                      rf_write_enable,
  output logic [REG_INDEX_BITS-1:0] rf_write_index,
  output logic [31:0]               rf_write_value,
  output logic                      flags_write_enable,
  output logic [31:0]               flags_write_value,
  output logic [31:0]               mem_address,
  output logic [31:0]               mem_writedata,
  output logic                      mem_write,
  input  logic                      mem_waitrequest,
`ifdef WRITE_BACK_RETIRE_COUNT_EN
  output logic [31:0]               retired_count,
`endif
  output logic [31:0]               retired_pc,
  output logic                      has_flushed
);
  typedef enum logic [1:0] {IDLE, STORE, UPDATE} state_t;
  localparam logic [REG_INDEX_BITS-1:0] flags_index = REG_INDEX_BITS'(FLAGS_REG);
  state_t state;
  logic [31:0] adj, store_pc, base;
  logic dest_zero;
  assign hold = reset_n && state != IDLE;
  assign rf_read_index = in_destination_register;
  assign dest_zero = in_destination_register == '0;
  // Writes issued last cycle have not reached the register file yet; forward them.
  always_comb
    base = (rf_write_enable && rf_write_index == rf_read_index) ? rf_write_value :
           (flags_write_enable && rf_read_index == flags_index) ? flags_write_value : rf_read_value;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      rf_write_enable <= 1'b0;
      rf_write_index <= '0;
      rf_write_value <= '0;
      flags_write_enable <= 1'b0;
      flags_write_value <= '0;
      mem_address <= '0;
      mem_writedata <= '0;
      mem_write <= 1'b0;
      retired_pc <= '0;
      has_flushed <= 1'b0;
      adj <= '0;
      store_pc <= '0;
    end else begin
      rf_write_enable <= 1'b0;
      flags_write_enable <= 1'b0;
      case (state)
        IDLE: begin
          has_flushed <= in_has_flushed;
          if (in_valid) begin
            rf_write_index <= in_destination_register;
            if (!in_is_writing_memory) begin
              rf_write_enable <= !dest_zero;
              rf_write_value <= in_destination_value;
              flags_write_enable <= 1'b1;
              flags_write_value <= {1'b0, in_flags, 27'd0};
              retired_pc <= in_pc;
            end else if (dest_zero) begin
              retired_pc <= in_pc;
            end else begin
              mem_write <= 1'b1;
              mem_address <= base;
              mem_writedata <= in_destination_value;
              adj <= in_adjustment_value;
              store_pc <= in_pc;
              state <= STORE;
            end
          end
        end
        STORE:
          if (!mem_waitrequest) begin
            mem_write <= 1'b0;
            retired_pc <= store_pc;
            rf_write_enable <= adj != '0;
            rf_write_value <= mem_address + adj;
            state <= adj != '0 ? UPDATE : IDLE;
          end
        default: state <= IDLE;
      endcase
    end
`ifdef WRITE_BACK_RETIRE_COUNT_EN
  logic commit;
  assign commit = (state == IDLE && in_valid && !in_has_flushed && (!in_is_writing_memory || dest_zero)) ||
                  (state == STORE && !mem_waitrequest);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) retired_count <= '0;
    else if (commit) retired_count <= retired_count + 32'd1;
`endif
endmodule

// File: tb/tb_write_back.sv
// tb_write_back: directed vector table plus multi-cycle store sequences for write_back.
module tb_write_back;
  logic clock = 1'b0, reset_n = 1'b0;
  logic in_valid = 1'b0, in_is_writing_memory = 1'b0, in_has_flushed = 1'b0, mem_waitrequest = 1'b0;
  logic [31:0] in_pc = '0, in_destination_value = '0, in_adjustment_value = '0, rf_read_value = '0;
  logic [4:0] in_destination_register = '0;
  logic [3:0] in_flags = '0;
  logic hold, rf_write_enable, flags_write_enable, mem_write, has_flushed;
  logic [4:0] rf_read_index, rf_write_index;
  logic [31:0] rf_write_value, flags_write_value, mem_address, mem_writedata, retired_pc;
`ifdef WRITE_BACK_RETIRE_COUNT_EN
  logic [31:0] retired_count;
`endif
  int n_cmp = 0, n_err = 0;

  write_back dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_pc(in_pc),
    .in_destination_register(in_destination_register), .in_is_writing_memory(in_is_writing_memory),
    .in_flags(in_flags), .in_destination_value(in_destination_value),
    .in_adjustment_value(in_adjustment_value), .in_has_flushed(in_has_flushed), .hold(hold),
    .rf_read_index(rf_read_index), .rf_read_value(rf_read_value), .rf_write_enable(rf_write_enable),
    .rf_write_index(rf_write_index), .rf_write_value(rf_write_value),
    .flags_write_enable(flags_write_enable), .flags_write_value(flags_write_value),
    .mem_address(mem_address), .mem_writedata(mem_writedata), .mem_write(mem_write),
    .mem_waitrequest(mem_waitrequest),
`ifdef WRITE_BACK_RETIRE_COUNT_EN
    .retired_count(retired_count),
`endif
    .retired_pc(retired_pc), .has_flushed(has_flushed)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic present(input logic mem, input logic [4:0] dest, input logic [31:0] value,
                         input logic [31:0] adjust, input logic [31:0] pc, input logic [31:0] rd);
    @(negedge clock);
    in_valid = 1'b1;
    in_is_writing_memory = mem;
    in_destination_register = dest;
    in_destination_value = value;
    in_adjustment_value = adjust;
    in_pc = pc;
    rf_read_value = rd;
    in_flags = 4'b0000;
    in_has_flushed = 1'b0;
  endtask

  task automatic idle_inputs();
    @(negedge clock);
    in_valid = 1'b0;
    in_is_writing_memory = 1'b0;
  endtask

  typedef struct {
    logic valid, mem, flushed;
    logic [4:0] dest;
    logic [31:0] value;
    logic [3:0] flags;
    logic [31:0] pc;
    logic rf_we, fwe;
    logic [31:0] fval, rpc;
    logic hf;
  } vec_t;

  vec_t vecs[6];
  int high;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 5'd5, 32'h12345678, 4'b1001, 32'h100, 1'b1, 1'b1, 32'h48000000, 32'h100, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 5'd0, 32'hFFFFFFFF, 4'b0110, 32'h104, 1'b0, 1'b1, 32'h30000000, 32'h104, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 5'd7, 32'h00000077, 4'b1111, 32'h200, 1'b0, 1'b0, 32'h0, 32'h104, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 5'd0, 32'h0000BEEF, 4'b1111, 32'h108, 1'b0, 1'b0, 32'h0, 32'h108, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 5'd1, 32'hA5A5A5A5, 4'b0000, 32'h10C, 1'b1, 1'b1, 32'h00000000, 32'h10C, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 5'd2, 32'h00000042, 4'b1000, 32'h110, 1'b1, 1'b1, 32'h40000000, 32'h110, 1'b1};

    #12;
    chk("reset hold", hold, 0);
    chk("reset rf_we", rf_write_enable, 0);
    chk("reset flags_we", flags_write_enable, 0);
    chk("reset mem_write", mem_write, 0);
    chk("reset retired_pc", retired_pc, 0);
    chk("reset has_flushed", has_flushed, 0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      in_valid = vecs[i].valid;
      in_is_writing_memory = vecs[i].mem;
      in_has_flushed = vecs[i].flushed;
      in_destination_register = vecs[i].dest;
      in_destination_value = vecs[i].value;
      in_flags = vecs[i].flags;
      in_pc = vecs[i].pc;
      #1 chk($sformatf("v%0d rf_read_index", i), rf_read_index, vecs[i].dest);
      tick();
      chk($sformatf("v%0d rf_we", i), rf_write_enable, vecs[i].rf_we);
      if (vecs[i].rf_we) begin
        chk($sformatf("v%0d rf_idx", i), rf_write_index, vecs[i].dest);
        chk($sformatf("v%0d rf_val", i), rf_write_value, vecs[i].value);
      end
      chk($sformatf("v%0d flags_we", i), flags_write_enable, vecs[i].fwe);
      if (vecs[i].fwe) chk($sformatf("v%0d flags_val", i), flags_write_value, vecs[i].fval);
      chk($sformatf("v%0d retired_pc", i), retired_pc, vecs[i].rpc);
      chk($sformatf("v%0d hold", i), hold, 0);
      chk($sformatf("v%0d mem_write", i), mem_write, 0);
      chk($sformatf("v%0d has_flushed", i), has_flushed, vecs[i].hf);
    end

    // Store with three stalled cycles: mem_write stays up four cycles.
    present(1'b1, 5'd3, 32'h0000CAFE, 32'h0, 32'h300, 32'h1000);
    in_flags = 4'b1111;
    mem_waitrequest = 1'b1;
    tick();
    in_valid = 1'b0;
    high = 0;
    for (int i = 0; i < 20 && mem_write; i++) begin
      high++;
      chk("stall addr", mem_address, 32'h1000);
      chk("stall data", mem_writedata, 32'hCAFE);
      chk("stall hold", hold, 1);
      chk("stall rf_we", rf_write_enable, 0);
      chk("stall flags_we", flags_write_enable, 0);
      mem_waitrequest = high < 4;
      tick();
    end
    chk("stall cycles", high, 4);
    chk("stall hold end", hold, 0);
    chk("stall rf_we end", rf_write_enable, 0);
    chk("stall retired_pc", retired_pc, 32'h300);

    // Post-adjust store without stall.
    present(1'b1, 5'd3, 32'h00001111, 32'd4, 32'h400, 32'h2000);
    mem_waitrequest = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("adj mem_write", mem_write, 1);
    chk("adj addr", mem_address, 32'h2000);
    chk("adj hold1", hold, 1);
    tick();
    chk("adj mem_write drop", mem_write, 0);
    chk("adj rf_we", rf_write_enable, 1);
    chk("adj rf_idx", rf_write_index, 3);
    chk("adj rf_val", rf_write_value, 32'h2004);
    chk("adj hold2", hold, 1);
    chk("adj retired_pc", retired_pc, 32'h400);
    tick();
    chk("adj hold end", hold, 0);
    chk("adj rf_we end", rf_write_enable, 0);

    // Bypass: store base comes from the in-flight write of r3.
    present(1'b0, 5'd3, 32'h00003000, 32'h0, 32'h500, 32'h0);
    tick();
    chk("byp rf_we", rf_write_enable, 1);
    present(1'b1, 5'd3, 32'h00000055, 32'h0, 32'h504, 32'hDEAD0000);
    tick();
    in_valid = 1'b0;
    chk("byp mem_write", mem_write, 1);
    chk("byp addr", mem_address, 32'h3000);
    tick();
    chk("byp done", mem_write, 0);

    // Reset during a stalled store with a pending post-adjust.
    present(1'b1, 5'd3, 32'h00000066, 32'd8, 32'h600, 32'h4000);
    mem_waitrequest = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("rst pre mem_write", mem_write, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst mem_write", mem_write, 0);
    chk("rst hold", hold, 0);
    idle_inputs();
    mem_waitrequest = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst no update", rf_write_enable, 0);
      chk("rst no mem", mem_write, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
